dds_cmd_regs: RTL and testbench

APB slave register bank that queues DDS channel commands in a FIFO and dispatches them to up to N_CH serial engines. Each engine uses a one-cycle Start pulse and a Busy handshake. Sits between the APB interconnect and the DDS engines. Unlike a single-channel register set, this block holds multiple outstanding commands, keeps per-channel readback registers and records sticky errors.

---
 rtl/dds_cmd_regs_if.sv | 24 ++
 rtl/dds_cmd_regs.sv | 312 +++++++++++++++++++++++++++++++
 tb/tb_dds_cmd_regs.sv | 394 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dds_cmd_regs_if.sv
// dds_cmd_regs_if
//   APB bus bundle between the interconnect and the DDS command register bank.
//   master : drives paddr/psel/penable/pwrite/pwdata, receives prdata/pready/pslverr
//   slave  : the register bank side of the same signals
interface dds_cmd_regs_if;
  logic [31:0] paddr;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  modport master (
    output paddr, psel, penable, pwrite, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  paddr, psel, penable, pwrite, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/dds_cmd_regs.sv
// dds_cmd_regs
//   APB register bank that queues DDS channel commands in a FIFO and dispatches
//   them one at a time to N_CH serial engines using a Start pulse / Busy
//   handshake. Keeps per-channel readback words and sticky error flags.
//
// Ports
//   APB_0_axiclk   in   clock
//   APB_0_aresetn  in   asynchronous active-low reset
//   APB_S_0        slave modport of dds_cmd_regs_if (APB bus)
//   Start          out  [N_CH]     one-hot, one-cycle start pulse
//   Busy           in   [N_CH]     per-channel busy
//   DataOut        out  [DW]       command data, shared by all channels
//   WR             out             command write flag, shared by all channels
//   DataIn         in   [N_CH*DW]  readback, channel c at [c*DW +: DW]
//
// Optional feature: define DDS_CMD_TIMEOUT_EN to abandon a command whose Busy
// never rises within TIMEOUT cycles (sets sticky TMO). Without it, WAIT_B
// waits indefinitely and TMO reads 0.
//
// Dispatcher states
//   state    | meaning
//   S_IDLE   | no command active; pops the FIFO head when EN and non-empty
//   S_ISSUE  | Start[ch] asserted for this single cycle
//   S_WAIT_B | waiting for Busy[ch] to rise (optionally bounded by TIMEOUT)
//   S_WAIT_D | waiting for Busy[ch] to fall; readback captured on that cycle
module dds_cmd_regs #(
  parameter int N_CH       = 4,
  parameter int DW         = 32,
  parameter int FIFO_DEPTH = 8,
  parameter int TIMEOUT    = 1024
) (
  input  logic                 APB_0_axiclk,
  input  logic                 APB_0_aresetn,
  dds_cmd_regs_if.slave        APB_S_0,
  output logic [N_CH-1:0]      Start,
  input  logic [N_CH-1:0]      Busy,
  output logic [DW-1:0]        DataOut,
  output logic                 WR,
  input  logic [N_CH*DW-1:0]   DataIn
);

  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int LW  = AW + 1;
  localparam int CHW = (N_CH > 1) ? $clog2(N_CH) : 1;
`ifdef DDS_CMD_TIMEOUT_EN
  localparam int TCW = $clog2(TIMEOUT + 1);
`endif

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ISSUE  = 2'd1,
    S_WAIT_B = 2'd2,
    S_WAIT_D = 2'd3
  } state_t;

  typedef struct packed {
    logic [CHW-1:0] ch;
    logic           wr;
    logic [DW-1:0]  data;
  } cmd_t;

  // APB handshake and decode
  logic        pready_q, pready_d;
  logic        access, wr_acc;
  logic [7:0]  addr;
  logic        wr_ctrl, wr_status, wr_data, wr_cmd;
  logic [3:0]  cmd_ch_raw;
  logic        cmd_ch_ok;
  cmd_t        new_cmd;

  // configuration / staging
  logic          en_q, en_d;
  logic [DW-1:0] data_q, data_d;

  // command FIFO
  cmd_t          mem_q [FIFO_DEPTH];
  cmd_t          mem_d [FIFO_DEPTH];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          push, pop, flush, full, empty;
  cmd_t          head;

  // dispatcher
  state_t          state_q, state_d;
  logic [CHW-1:0]  ch_q, ch_d;
  logic [DW-1:0]   dout_q, dout_d;
  logic            wr_q, wr_d;
  logic [DW-1:0]   rdata_q [N_CH];
  logic [DW-1:0]   rdata_d [N_CH];
  logic            busy_cur;
  logic [N_CH-1:0] start_c;

  // sticky flags
  logic ovf_q, ovf_d, badch_q, badch_d;
  logic ovf_set, badch_set, tmo_flag;
`ifdef DDS_CMD_TIMEOUT_EN
  logic           tmo_q, tmo_d, tmo_set;
  logic [TCW-1:0] tmo_cnt_q, tmo_cnt_d;
`endif

  logic [31:0] status;
  logic [31:0] prdata_c;
  logic        unused_bits;

  assign unused_bits = ^{APB_S_0.paddr[31:8], APB_S_0.pwdata};

  always_comb begin
    addr       = APB_S_0.paddr[7:0];
    pready_d   = APB_S_0.psel & APB_S_0.penable & ~pready_q;
    // side effects only on the completion cycle so every write lands once
    access     = APB_S_0.psel & APB_S_0.penable & pready_q;
    wr_acc     = access & APB_S_0.pwrite;
    wr_ctrl    = wr_acc && (addr == 8'h00);
    wr_status  = wr_acc && (addr == 8'h04);
    wr_data    = wr_acc && (addr == 8'h08);
    wr_cmd     = wr_acc && (addr == 8'h0C);
    cmd_ch_raw = APB_S_0.pwdata[11:8];
    cmd_ch_ok  = ({1'b0, cmd_ch_raw} < 5'(N_CH));
    full       = (level_q == LW'(FIFO_DEPTH));
    empty      = (level_q == '0);
    flush      = wr_ctrl & APB_S_0.pwdata[1];
    push       = wr_cmd & cmd_ch_ok & ~full;
    ovf_set    = wr_cmd & cmd_ch_ok & full;
    badch_set  = wr_cmd & ~cmd_ch_ok;
    new_cmd.ch   = cmd_ch_raw[CHW-1:0];
    new_cmd.wr   = APB_S_0.pwdata[0];
    new_cmd.data = data_q;
    head         = mem_q[rptr_q];
  end

  always_comb begin
    en_d   = en_q;
    data_d = data_q;
    if (wr_ctrl) en_d = APB_S_0.pwdata[0];
    if (wr_data) data_d = APB_S_0.pwdata[DW-1:0];
  end

  // FIFO: pointers wrap naturally at FIFO_DEPTH (power of two); flush wins
  always_comb begin
    mem_d   = mem_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    if (push) begin
      mem_d[wptr_q] = new_cmd;
      wptr_d        = wptr_q + 1'b1;
    end
    if (pop) rptr_d = rptr_q + 1'b1;
    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
    if (flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      level_d = '0;
    end
  end

  always_comb begin
    busy_cur = 1'b0;
    start_c  = '0;
    for (int c = 0; c < N_CH; c++) begin
      if (ch_q == CHW'(c)) begin
        busy_cur   = Busy[c];
        start_c[c] = (state_q == S_ISSUE);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    dout_d  = dout_q;
    wr_d    = wr_q;
    pop     = 1'b0;
    rdata_d = rdata_q;
`ifdef DDS_CMD_TIMEOUT_EN
    tmo_set   = 1'b0;
    tmo_cnt_d = tmo_cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (en_q && !empty) begin
          pop     = 1'b1;
          ch_d    = head.ch;
          dout_d  = head.data;
          wr_d    = head.wr;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT_B;
`ifdef DDS_CMD_TIMEOUT_EN
        // down-counter covers TIMEOUT WAIT_B cycles, expiring at zero
        tmo_cnt_d = TCW'(TIMEOUT - 1);
`endif
      end
      S_WAIT_B: begin
        if (busy_cur) state_d = S_WAIT_D;
`ifdef DDS_CMD_TIMEOUT_EN
        else if (tmo_cnt_q == '0) begin
          tmo_set = 1'b1;
          state_d = S_IDLE;
        end
        else tmo_cnt_d = tmo_cnt_q - 1'b1;
`endif
      end
      S_WAIT_D: begin
        if (!busy_cur) begin
          for (int c = 0; c < N_CH; c++) begin
            if (ch_q == CHW'(c)) rdata_d[c] = DataIn[c*DW +: DW];
          end
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // sticky flags: a set in the same cycle as a W1C clear keeps the flag
  always_comb begin
    ovf_d   = ovf_q;
    badch_d = badch_q;
    if (wr_status && APB_S_0.pwdata[16]) ovf_d = 1'b0;
    if (wr_status && APB_S_0.pwdata[18]) badch_d = 1'b0;
    if (ovf_set) ovf_d = 1'b1;
    if (badch_set) badch_d = 1'b1;
`ifdef DDS_CMD_TIMEOUT_EN
    tmo_d = tmo_q;
    if (wr_status && APB_S_0.pwdata[17]) tmo_d = 1'b0;
    if (tmo_set) tmo_d = 1'b1;
    tmo_flag = tmo_q;
`else
    tmo_flag = 1'b0;
`endif
  end

  always_comb begin
    status          = '0;
    status[0]       = busy_cur;
    status[1]       = (state_q != S_IDLE);
    status[2]       = empty;
    status[3]       = full;
    status[8 +: LW] = level_q;
    status[16]      = ovf_q;
    status[17]      = tmo_flag;
    status[18]      = badch_q;

    prdata_c = '0;
    case (addr)
      8'h00:   prdata_c = {31'b0, en_q};
      8'h04:   prdata_c = status;
      8'h08:   prdata_c = 32'(data_q);
      default: prdata_c = '0;
    endcase
    for (int c = 0; c < N_CH; c++) begin
      if (addr == 8'(16 + 4*c)) prdata_c = 32'(rdata_q[c]);
    end
  end

  always_ff @(posedge APB_0_axiclk or negedge APB_0_aresetn) begin
    if (!APB_0_aresetn) begin
      pready_q <= 1'b0;
      en_q     <= 1'b0;
      data_q   <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wptr_q   <= '0;
      rptr_q   <= '0;
      level_q  <= '0;
      state_q  <= S_IDLE;
      ch_q     <= '0;
      dout_q   <= '0;
      wr_q     <= 1'b0;
      for (int c = 0; c < N_CH; c++) rdata_q[c] <= '0;
      ovf_q    <= 1'b0;
      badch_q  <= 1'b0;
`ifdef DDS_CMD_TIMEOUT_EN
      tmo_q     <= 1'b0;
      tmo_cnt_q <= '0;
`endif
    end else begin
      pready_q <= pready_d;
      en_q     <= en_d;
      data_q   <= data_d;
      mem_q    <= mem_d;
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      level_q  <= level_d;
      state_q  <= state_d;
      ch_q     <= ch_d;
      dout_q   <= dout_d;
      wr_q     <= wr_d;
      rdata_q  <= rdata_d;
      ovf_q    <= ovf_d;
      badch_q  <= badch_d;
`ifdef DDS_CMD_TIMEOUT_EN
      tmo_q     <= tmo_d;
      tmo_cnt_q <= tmo_cnt_d;
`endif
    end
  end

  assign Start           = start_c;
  assign DataOut         = dout_q;
  assign WR              = wr_q;
  assign APB_S_0.prdata  = prdata_c;
  assign APB_S_0.pready  = pready_q;
  assign APB_S_0.pslverr = 1'b0;

endmodule

// File: tb/tb_dds_cmd_regs.sv
// tb_dds_cmd_regs
//   Directed bench for dds_cmd_regs: a table of APB register accesses with
//   hand-computed expectations, followed by hand-written multi-cycle sequences
//   driven against a simple engine responder that answers Start with Busy.
module tb_dds_cmd_regs;
  localparam int N_CH  = 4;
  localparam int DW    = 32;
  localparam int DEPTH = 8;
`ifdef DDS_CMD_TIMEOUT_EN
  localparam int TMO_P = 16;
`else
  localparam int TMO_P = 1024;
`endif

  logic                 clk;
  logic                 rst_n;
  logic [N_CH-1:0]      Start;
  logic [N_CH-1:0]      Busy;
  logic [DW-1:0]        DataOut;
  logic                 WR;
  logic [N_CH*DW-1:0]   DataIn;

  dds_cmd_regs_if apb ();

  dds_cmd_regs #(.N_CH(N_CH), .DW(DW), .FIFO_DEPTH(DEPTH), .TIMEOUT(TMO_P)) dut (
    .APB_0_axiclk (clk),
    .APB_0_aresetn(rst_n),
    .APB_S_0      (apb.slave),
    .Start        (Start),
    .Busy         (Busy),
    .DataOut      (DataOut),
    .WR           (WR),
    .DataIn       (DataIn)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc;
  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // ---------------- engine responder ----------------
  logic         resp_en   = 1'b1;
  logic         echo_mode = 1'b0;
  int           busy_len  = 5;
  int           st_n      = 0;
  int           st_ch   [64];
  int           st_cyc  [64];
  logic [31:0]  st_dout [64];
  logic         st_wr   [64];
  int           shape_err = 0;
  int           gap_err   = 0;
  int           stab_err  = 0;
  int           last_fall = 0;
  logic         fall_valid = 1'b0;
  int           busy_cnt [N_CH];
  logic [N_CH-1:0] prev_start;
  logic [DW-1:0]   cur_dout;
  logic            cur_wr;

  initial begin
    Busy       = '0;
    DataIn     = '0;
    DataIn[2*DW +: DW] = 32'h0000_1234;
    prev_start = '0;
    cur_dout   = '0;
    cur_wr     = 1'b0;
    for (int c = 0; c < N_CH; c++) busy_cnt[c] = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        Busy = '0;
        for (int c = 0; c < N_CH; c++) busy_cnt[c] = 0;
        prev_start = '0;
      end else begin
        for (int c = 0; c < N_CH; c++) begin
          if (busy_cnt[c] > 0 && (DataOut !== cur_dout || WR !== cur_wr)) stab_err++;
        end
        for (int c = 0; c < N_CH; c++) begin
          if (busy_cnt[c] > 0) begin
            busy_cnt[c]--;
            if (busy_cnt[c] == 0) begin
              Busy[c]    = 1'b0;
              last_fall  = cyc;
              fall_valid = 1'b1;
            end
          end
        end
        if (Start != '0) begin
          if ($countones(Start) != 1 || Start == prev_start) shape_err++;
          for (int c = 0; c < N_CH; c++) begin
            if (Start[c]) begin
              st_ch[st_n]   = c;
              st_cyc[st_n]  = cyc;
              st_dout[st_n] = DataOut;
              st_wr[st_n]   = WR;
              if (fall_valid && (cyc - last_fall) < 2) gap_err++;
              cur_dout = DataOut;
              cur_wr   = WR;
              if (echo_mode) DataIn[c*DW +: DW] = DataOut ^ 32'hFFFF_0000;
              if (resp_en) begin
                Busy[c]     = 1'b1;
                busy_cnt[c] = busy_len;
              end
            end
          end
          if (st_n < 63) st_n++;
        end
        prev_start = Start;
      end
    end
  end

  // ---------------- APB master ----------------
  task automatic apb_xfer(input logic wr, input logic [7:0] a, input logic [31:0] wd,
                          output logic [31:0] rd, output int cmpl);
    int n;
    @(negedge clk);
    apb.paddr   = {24'h0, a};
    apb.pwrite  = wr;
    apb.pwdata  = wd;
    apb.psel    = 1'b1;
    apb.penable = 1'b0;
    @(negedge clk);
    apb.penable = 1'b1;
    n = 0;
    while (!apb.pready && n < 16) begin
      @(negedge clk);
      n++;
    end
    if (!apb.pready) begin
      n_chk++;
      $display("FAIL apb_pready: got 0 expected 1 at addr 0x%02h", a);
    end
    rd   = apb.prdata;
    cmpl = cyc;
    @(negedge clk);
    apb.psel    = 1'b0;
    apb.penable = 1'b0;
    apb.pwrite  = 1'b0;
  endtask

  task automatic wr_reg(input logic [7:0] a, input logic [31:0] d);
    logic [31:0] r;
    int t;
    apb_xfer(1'b1, a, d, r, t);
  endtask

  task automatic rd_reg(input logic [7:0] a, output logic [31:0] d);
    int t;
    apb_xfer(1'b0, a, 32'h0, d, t);
  endtask

  task automatic rd_chk(input string name, input logic [7:0] a, input logic [31:0] exp);
    logic [31:0] r;
    rd_reg(a, r);
    chk(name, r, exp);
  endtask

  task automatic wait_starts(input string name, input int target, input int budget);
    int n = 0;
    while (st_n < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(name, st_n, target);
  endtask

  task automatic wait_idle(input string name);
    logic [31:0] s;
    int n = 0;
    do begin
      rd_reg(8'h04, s);
      n++;
    end while (s[1] && n < 60);
    chk(name, {31'b0, s[1]}, 32'h0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        wr;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[$];

  initial begin
    logic [31:0] r;
    int t, base, g0;

    apb.paddr = '0; apb.psel = 1'b0; apb.penable = 1'b0; apb.pwrite = 1'b0; apb.pwdata = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_start", {28'b0, Start}, 32'h0);
    chk("rst_dout", DataOut, 32'h0);
    chk("rst_wr", {31'b0, WR}, 32'h0);
    chk("rst_pready", {31'b0, apb.pready}, 32'h0);
    chk("rst_pslverr", {31'b0, apb.pslverr}, 32'h0);
    rst_n = 1'b1;

    vecs.push_back('{1'b0, 8'h00, 32'h0,         32'h0000_0000, "rst_ctrl"});
    vecs.push_back('{1'b0, 8'h04, 32'h0,         32'h0000_0004, "rst_status"});
    vecs.push_back('{1'b0, 8'h08, 32'h0,         32'h0000_0000, "rst_data"});
    vecs.push_back('{1'b0, 8'h10, 32'h0,         32'h0000_0000, "rst_rdata0"});
    vecs.push_back('{1'b0, 8'h1C, 32'h0,         32'h0000_0000, "rst_rdata3"});
    vecs.push_back('{1'b1, 8'h08, 32'hA5A5_0001, 32'h0,         "w_data"});
    vecs.push_back('{1'b0, 8'h08, 32'h0,         32'hA5A5_0001, "data_rw"});
    vecs.push_back('{1'b1, 8'h00, 32'h0000_0002, 32'h0,         "w_flush"});
    vecs.push_back('{1'b0, 8'h00, 32'h0,         32'h0000_0000, "flush_reads0"});
    vecs.push_back('{1'b1, 8'h00, 32'h0000_0001, 32'h0,         "w_en"});
    vecs.push_back('{1'b0, 8'h00, 32'h0,         32'h0000_0001, "en_rw"});
    vecs.push_back('{1'b1, 8'h00, 32'h0000_0000, 32'h0,         "w_en0"});
    vecs.push_back('{1'b0, 8'h00, 32'h0,         32'h0000_0000, "en_clr"});
    vecs.push_back('{1'b1, 8'h0C, 32'h0000_0401, 32'h0,         "w_cmd_ch4"});
    vecs.push_back('{1'b0, 8'h04, 32'h0,         32'h0004_0004, "badch_ch4"});
    vecs.push_back('{1'b1, 8'h04, 32'h0004_0000, 32'h0,         "w_badch_clr"});
    vecs.push_back('{1'b0, 8'h04, 32'h0,         32'h0000_0004, "badch_w1c"});
    vecs.push_back('{1'b1, 8'h04, 32'h0000_FFFF, 32'h0,         "w_status_ro"});
    vecs.push_back('{1'b0, 8'h04, 32'h0,         32'h0000_0004, "status_ro"});
    vecs.push_back('{1'b1, 8'h84, 32'hFFFF_FFFF, 32'h0,         "w_unmapped"});
    vecs.push_back('{1'b0, 8'h84, 32'h0,         32'h0000_0000, "unmapped_rd"});
    vecs.push_back('{1'b0, 8'h08, 32'h0,         32'hA5A5_0001, "unmapped_wr_ignored"});
    vecs.push_back('{1'b0, 8'h20, 32'h0,         32'h0000_0000, "rdata_c4"});
    vecs.push_back('{1'b1, 8'h0C, 32'h0000_0301, 32'h0,         "w_cmd_ch3"});
    vecs.push_back('{1'b0, 8'h04, 32'h0,         32'h0000_0100, "push_one"});
    vecs.push_back('{1'b1, 8'h00, 32'h0000_0002, 32'h0,         "w_flush2"});
    vecs.push_back('{1'b0, 8'h04, 32'h0,         32'h0000_0004, "flush_empty"});

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].wr) wr_reg(vecs[i].addr, vecs[i].wdata);
      else rd_chk(vecs[i].name, vecs[i].addr, vecs[i].exp);
    end

    // overflow: 9 pushes into an 8-deep FIFO with dispatch disabled
    for (int i = 0; i < 9; i++) begin
      wr_reg(8'h0C, 32'h0000_0001 | ((i % 4) << 8));
      if (i == 6) rd_chk("level7", 8'h04, 32'h0000_0700);
    end
    rd_chk("ovf_full", 8'h04, 32'h0001_0808);
    wr_reg(8'h04, 32'h0001_0000);
    rd_chk("ovf_w1c", 8'h04, 32'h0000_0808);
    wr_reg(8'h00, 32'h0000_0002);
    rd_chk("ovf_flush", 8'h04, 32'h0000_0004);

    // bad channel with dispatch enabled
    wr_reg(8'h00, 32'h0000_0001);
    base = st_n;
    wr_reg(8'h0C, 32'h0000_0501);
    repeat (8) @(negedge clk);
    chk("badch_nostart", st_n, base);
    rd_chk("badch_ch5", 8'h04, 32'h0004_0004);
    wr_reg(8'h04, 32'h0004_0000);

    // basic command on channel 2
    wr_reg(8'h00, 32'h0);
    echo_mode = 1'b0;
    busy_len  = 5;
    wr_reg(8'h08, 32'hA5A5_0001);
    wr_reg(8'h0C, 32'h0000_0201);
    base = st_n;
    apb_xfer(1'b1, 8'h00, 32'h0000_0001, r, t);
    wait_starts("basic_start", base + 1, 50);
    chk("basic_ch", st_ch[base], 2);
    chk("basic_latency", st_cyc[base] - t, 2);
    chk("basic_dout", st_dout[base], 32'hA5A5_0001);
    chk("basic_wr", {31'b0, st_wr[base]}, 32'h1);
    wait_idle("basic_idle");
    rd_chk("basic_rdata2", 8'h18, 32'h0000_1234);
    chk("basic_dout_hold", DataOut, 32'hA5A5_0001);

    // back-to-back: channels 0, 1, 0
    wr_reg(8'h00, 32'h0);
    echo_mode = 1'b1;
    busy_len  = 3;
    base = st_n;
    g0 = gap_err;
    wr_reg(8'h08, 32'h0000_0011); wr_reg(8'h0C, 32'h0000_0001);
    wr_reg(8'h08, 32'h0000_0022); wr_reg(8'h0C, 32'h0000_0100);
    wr_reg(8'h08, 32'h0000_0033); wr_reg(8'h0C, 32'h0000_0001);
    wr_reg(8'h00, 32'h0000_0001);
    wait_starts("b2b_starts", base + 3, 200);
    wait_idle("b2b_idle");
    chk("b2b_ch0", st_ch[base], 0);
    chk("b2b_ch1", st_ch[base+1], 1);
    chk("b2b_ch2", st_ch[base+2], 0);
    chk("b2b_dout0", st_dout[base], 32'h11);
    chk("b2b_dout1", st_dout[base+1], 32'h22);
    chk("b2b_dout2", st_dout[base+2], 32'h33);
    chk("b2b_wr", {29'b0, st_wr[base], st_wr[base+1], st_wr[base+2]}, 32'h5);
    chk("b2b_spacing", st_cyc[base+1] - st_cyc[base], 5);
    chk("b2b_gap", gap_err - g0, 0);
    rd_chk("b2b_rdata0", 8'h10, 32'hFFFF_0033);
    rd_chk("b2b_rdata1", 8'h14, 32'hFFFF_0022);

    // flush while one command is in flight and two are queued
    wr_reg(8'h00, 32'h0);
    busy_len = 20;
    base = st_n;
    wr_reg(8'h08, 32'h0000_0044); wr_reg(8'h0C, 32'h0000_0301);
    wr_reg(8'h08, 32'h0000_0055); wr_reg(8'h0C, 32'h0000_0301);
    wr_reg(8'h08, 32'h0000_0066); wr_reg(8'h0C, 32'h0000_0300);
    wr_reg(8'h00, 32'h0000_0001);
    wait_starts("flush_start", base + 1, 50);
    rd_chk("flush_pre", 8'h04, 32'h0000_0203);
    wr_reg(8'h00, 32'h0000_0003);
    rd_chk("flush_post", 8'h04, 32'h0000_0007);
    wait_idle("flush_idle");
    repeat (10) @(negedge clk);
    chk("flush_one_start", st_n - base, 1);
    rd_chk("flush_rdata3", 8'h1C, 32'hFFFF_0044);

    // reset asserted during WAIT_D
    wr_reg(8'h00, 32'h0);
    busy_len = 30;
    base = st_n;
    wr_reg(8'h08, 32'hDEAD_BEEF);
    wr_reg(8'h0C, 32'h0000_0101);
    wr_reg(8'h00, 32'h0000_0001);
    wait_starts("rst_mid_start", base + 1, 50);
    repeat (4) @(negedge clk);
    rd_chk("pre_rst_status", 8'h04, 32'h0000_0007);
    chk("pre_rst_dout", DataOut, 32'hDEAD_BEEF);
    @(negedge clk);
    apb.paddr = 32'h0000_0004;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_start", {28'b0, Start}, 32'h0);
    chk("mid_rst_dout", DataOut, 32'h0);
    chk("mid_rst_wr", {31'b0, WR}, 32'h0);
    chk("mid_rst_pready", {31'b0, apb.pready}, 32'h0);
    chk("mid_rst_status", apb.prdata, 32'h0000_0004);
    apb.paddr = 32'h0000_0014;
    #1;
    chk("mid_rst_rdata1", apb.prdata, 32'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    rd_chk("post_rst_ctrl", 8'h00, 32'h0);

`ifdef DDS_CMD_TIMEOUT_EN
    // Busy never rises: each command times out after TIMEOUT WAIT_B cycles
    resp_en = 1'b0;
    base = st_n;
    wr_reg(8'h08, 32'h0000_0077); wr_reg(8'h0C, 32'h0000_0201);
    wr_reg(8'h08, 32'h0000_0088); wr_reg(8'h0C, 32'h0000_0101);
    wr_reg(8'h00, 32'h0000_0001);
    wait_starts("tmo_starts", base + 2, 100);
    chk("tmo_ch_first", st_ch[base], 2);
    chk("tmo_ch_second", st_ch[base+1], 1);
    chk("tmo_spacing", st_cyc[base+1] - st_cyc[base], 18);
    repeat (20) @(negedge clk);
    rd_chk("tmo_status", 8'h04, 32'h0002_0004);
    rd_chk("tmo_rdata2", 8'h18, 32'h0);
    wr_reg(8'h04, 32'h0002_0000);
    rd_chk("tmo_w1c", 8'h04, 32'h0000_0004);
    resp_en = 1'b1;
`else
    rd_chk("tmo_absent", 8'h04, 32'h0000_0004);
`endif

    chk("start_shape", shape_err, 0);
    chk("start_gap", gap_err, 0);
    chk("dout_stable", stab_err, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
